multicycle_controller: RTL and testbench

- Main control unit of the RV32I multicycle core: a Moore FSM plus an ALU decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every datapath select and write enable, including the 2:1 address mux and the 3:1 SrcA, SrcB and Result muxes.
- Consumes the opcode, funct3 and funct7[5] fields from the instruction register, plus the ALU zero flag.

---
 rtl/riscv_ctrl_pkg.sv | 72 +++++++
 rtl/alu_decoder.sv | 35 +++
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 tb/tb_multicycle_controller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: none.
// Contents: opcode constants, FSM state enum, ALU-op enum, datapath select codes.
package riscv_ctrl_pkg;

  // Opcodes the controller understands; anything else is illegal.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_RESULT    = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_REG      = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  localparam logic [1:0] IMM_I         = 2'b00;
  localparam logic [1:0] IMM_S         = 2'b01;
  localparam logic [1:0] IMM_B         = 2'b10;
  localparam logic [1:0] IMM_J         = 2'b11;

  localparam logic [2:0] ALU_ADD       = 3'b000;
  localparam logic [2:0] ALU_SUB       = 3'b001;
  localparam logic [2:0] ALU_AND       = 3'b010;
  localparam logic [2:0] ALU_OR        = 3'b011;
  localparam logic [2:0] ALU_SLT       = 3'b101;

  // Immediate format is a pure function of the opcode, independent of state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's ALU request plus funct fields onto an ALU operation.
// Latency: purely combinational.
// Backpressure: none.
// Ports: alu_op (add/sub/funct request), funct3, funct7b5, op5 (op[5]) -> alu_control.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type, so addi never becomes sub
          // even when its immediate happens to set bit 30.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control unit of the RV32I multicycle core: Moore FSM plus ALU decoder.
// Latency: outputs combinational from state (imm_src from op, pc_write also from zero).
// Backpressure: none; one state step per clk, synchronous active-high reset.
// Ports: clk, reset, op/funct3/funct7b5/zero in; datapath enables, mux selects,
//        alu_control, imm_src, illegal flag and state_dbg out.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter logic ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t  state;
  state_t  next_state;
  state_t  out_state;
  alu_op_t alu_op;
  logic    pc_update;
  logic    branch;
  logic    ir_en;
  logic    mem_en;
  logic    reg_en;
  logic    ill_raw;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    // During reset the selects look like FETCH, whatever the register holds.
    out_state  = reset ? S_FETCH : state;
    next_state = state;
    adr_src    = ADR_PC;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_en      = 1'b0;
    mem_en     = 1'b0;
    reg_en     = 1'b0;
    ill_raw    = 1'b0;
    case (out_state)
      S_FETCH: begin
        ir_en      = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECUTER;
          OP_ITYPE:          next_state = S_EXECUTEI;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default: begin
            ill_raw    = 1'b1;
            next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = ADR_RESULT;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_en     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = ADR_RESULT;
        mem_en     = 1'b1;
        next_state = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = SRCA_REG;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_en     = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_REG;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      S_HALT: begin
        ill_raw    = 1'b1;
        next_state = S_HALT;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Every enable is masked by reset so an abandoned instruction writes nothing.
  assign pc_write  = ~reset & (pc_update | (branch & zero));
  assign ir_write  = ~reset & ir_en;
  assign mem_write = ~reset & mem_en;
  assign reg_write = ~reset & reg_en;
  assign illegal   = ~reset & ill_raw;
  assign imm_src   = imm_src_of(op);
  assign state_dbg = state;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;

  // h: ILLEGAL_HALT=1 instance, c: ILLEGAL_HALT=0 instance; both share inputs.
  logic       pc_write_h, adr_src_h, mem_write_h, ir_write_h, reg_write_h, illegal_h;
  logic [1:0] result_src_h, alu_src_a_h, alu_src_b_h, imm_src_h;
  logic [2:0] alu_control_h;
  logic [3:0] state_dbg_h;
  logic       pc_write_c, adr_src_c, mem_write_c, ir_write_c, reg_write_c, illegal_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, imm_src_c;
  logic [2:0] alu_control_c;
  logic [3:0] state_dbg_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write_h), .adr_src(adr_src_h), .mem_write(mem_write_h), .ir_write(ir_write_h),
    .result_src(result_src_h), .alu_src_a(alu_src_a_h), .alu_src_b(alu_src_b_h),
    .alu_control(alu_control_h), .imm_src(imm_src_h), .reg_write(reg_write_h),
    .illegal(illegal_h), .state_dbg(state_dbg_h)
  );

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_c (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write_c), .adr_src(adr_src_c), .mem_write(mem_write_c), .ir_write(ir_write_c),
    .result_src(result_src_c), .alu_src_a(alu_src_a_c), .alu_src_b(alu_src_b_c),
    .alu_control(alu_control_c), .imm_src(imm_src_c), .reg_write(reg_write_c),
    .illegal(illegal_c), .state_dbg(state_dbg_c)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal;
  } obs_t;

  function automatic obs_t obs_h();
    obs_t o;
    o.st = state_dbg_h; o.pc_write = pc_write_h; o.adr_src = adr_src_h;
    o.mem_write = mem_write_h; o.ir_write = ir_write_h; o.result_src = result_src_h;
    o.src_a = alu_src_a_h; o.src_b = alu_src_b_h; o.alu_control = alu_control_h;
    o.imm_src = imm_src_h; o.reg_write = reg_write_h; o.illegal = illegal_h;
    return o;
  endfunction

  function automatic obs_t obs_c();
    obs_t o;
    o.st = state_dbg_c; o.pc_write = pc_write_c; o.adr_src = adr_src_c;
    o.mem_write = mem_write_c; o.ir_write = ir_write_c; o.result_src = result_src_c;
    o.src_a = alu_src_a_c; o.src_b = alu_src_b_c; o.alu_control = alu_control_c;
    o.imm_src = imm_src_c; o.reg_write = reg_write_c; o.illegal = illegal_c;
    return o;
  endfunction

  // ---------------- reference model ----------------
  function automatic obs_t step(input state_t st, input logic [1:0] sa, input logic [1:0] sb,
                                input logic [1:0] rs, input logic [2:0] ac, input logic pcw,
                                input logic adr, input logic mw, input logic irw,
                                input logic rw, input logic ill);
    obs_t s;
    s.st = st; s.src_a = sa; s.src_b = sb; s.result_src = rs; s.alu_control = ac;
    s.pc_write = pcw; s.adr_src = adr; s.mem_write = mw; s.ir_write = irw;
    s.reg_write = rw; s.illegal = ill; s.imm_src = 2'b00;
    return s;
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7, input logic op5);
    if (f3 == 3'b000) return (op5 && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic obs_t fetch_step();
    return step(S_FETCH, 2'b00, 2'b10, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic obs_t aluwb_step();
    return step(S_ALUWB, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  // Runs one whole instruction from FETCH; zmode<0 randomises zero every cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input string tag);
    obs_t e[$];
    logic zq[6];
    obs_t got;
    for (int i = 0; i < 6; i++) zq[i] = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
    e.push_back(fetch_step());
    e.push_back(step(S_DECODE, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    case (o)
      7'b0000011: begin
        e.push_back(step(S_MEMADR, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0));
        e.push_back(step(S_MEMREAD, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1, 0, 0, 0, 0));
        e.push_back(step(S_MEMWB, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0, 0, 0, 1, 0));
      end
      7'b0100011: begin
        e.push_back(step(S_MEMADR, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0));
        e.push_back(step(S_MEMWRITE, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1, 1, 0, 0, 0));
      end
      7'b0110011: begin
        e.push_back(step(S_EXECUTER, 2'b10, 2'b00, 2'b00, ref_alu(f3, f7, o[5]), 0, 0, 0, 0, 0, 0));
        e.push_back(aluwb_step());
      end
      7'b0010011: begin
        e.push_back(step(S_EXECUTEI, 2'b10, 2'b01, 2'b00, ref_alu(f3, f7, o[5]), 0, 0, 0, 0, 0, 0));
        e.push_back(aluwb_step());
      end
      7'b1100011:
        e.push_back(step(S_BEQ, 2'b10, 2'b00, 2'b00, 3'b001, zq[2], 0, 0, 0, 0, 0));
      7'b1101111: begin
        e.push_back(step(S_JAL, 2'b01, 2'b10, 2'b00, 3'b000, 1, 0, 0, 0, 0, 0));
        e.push_back(aluwb_step());
      end
      default: ;
    endcase
    foreach (e[i]) e[i].imm_src = ref_imm(o);
    foreach (e[i]) begin
      op = o; funct3 = f3; funct7b5 = f7; zero = zq[i];
      #1;
      got = obs_h();
      n_cmp++;
      if (got !== e[i]) begin
        n_bad++;
        $display("FAIL %s cyc%0d halt-inst: got %h want %h", tag, i, got, e[i]);
      end
      got = obs_c();
      n_cmp++;
      if (got !== e[i]) begin
        n_bad++;
        $display("FAIL %s cyc%0d cont-inst: got %h want %h", tag, i, got, e[i]);
      end
      n_cmp++;
      if (got.src_a === 2'b11 || got.src_b === 2'b11 || got.result_src === 2'b11) begin
        n_bad++;
        $display("FAIL %s cyc%0d mux11: got a=%b b=%b r=%b want none 11", tag, i,
                 got.src_a, got.src_b, got.result_src);
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t want, got;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      want = fetch_step();
      want.pc_write = 1'b0; want.ir_write = 1'b0; want.st = 4'd0;
      want.imm_src = ref_imm(op);
      got = obs_h(); got.st = 4'd0;
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset_hold%0d halt-inst: got %h want %h", c, got, want);
      end
      got = obs_c(); got.st = 4'd0;
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset_hold%0d cont-inst: got %h want %h", c, got, want);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    want = fetch_step(); want.imm_src = ref_imm(op);
    n_cmp++;
    if (obs_h() !== want) begin
      n_bad++;
      $display("FAIL reset_release halt-inst: got %h want %h", obs_h(), want);
    end
    n_cmp++;
    if (obs_c() !== want) begin
      n_bad++;
      $display("FAIL reset_release cont-inst: got %h want %h", obs_c(), want);
    end
  endtask

  task automatic test_rtype();
    run_instr(7'b0110011, 3'b000, 1'b1, -1, "rtype_sub");
    run_instr(7'b0110011, 3'b111, 1'b0, -1, "rtype_and");
  endtask

  task automatic test_load_store();
    run_instr(7'b0000011, 3'b010, 1'b0, -1, "lw");
    run_instr(7'b0100011, 3'b010, 1'b1, -1, "sw");
  endtask

  task automatic test_branch();
    run_instr(7'b1100011, 3'b000, 1'b0, 1, "beq_taken");
    run_instr(7'b1100011, 3'b000, 1'b1, 0, "beq_not_taken");
  endtask

  task automatic test_jal();
    run_instr(7'b1101111, 3'b101, 1'b1, -1, "jal");
  endtask

  task automatic test_itype();
    run_instr(7'b0010011, 3'b000, 1'b1, -1, "addi_f7set");
    run_instr(7'b0010011, 3'b110, 1'b0, -1, "ori");
  endtask

  task automatic test_illegal();
    obs_t eh[$], ec[$];
    obs_t dec_ill;
    dec_ill = step(S_DECODE, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0, 0, 0, 0, 1);
    eh.push_back(fetch_step()); eh.push_back(dec_ill);
    ec.push_back(fetch_step()); ec.push_back(dec_ill);
    for (int i = 0; i < 2; i++) begin
      eh.push_back(step(S_HALT, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0, 0, 0, 1));
      eh.push_back(step(S_HALT, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0, 0, 0, 1));
      ec.push_back(fetch_step()); ec.push_back(dec_ill);
    end
    foreach (eh[i]) begin
      op = 7'b0000000; funct3 = 3'($urandom_range(0, 7)); zero = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (obs_h() !== eh[i]) begin
        n_bad++;
        $display("FAIL illegal_halt cyc%0d: got %h want %h", i, obs_h(), eh[i]);
      end
      n_cmp++;
      if (obs_c() !== ec[i]) begin
        n_bad++;
        $display("FAIL illegal_cont cyc%0d: got %h want %h", i, obs_c(), ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_memwrite();
    obs_t want;
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (state_dbg_h !== S_MEMWRITE || mem_write_h !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_memwrite: got st=%0d mw=%b want st=%0d mw=1",
               state_dbg_h, mem_write_h, S_MEMWRITE);
    end
    reset = 1'b1;
    #1;
    want = fetch_step();
    want.st = S_MEMWRITE; want.pc_write = 1'b0; want.ir_write = 1'b0; want.imm_src = 2'b01;
    n_cmp++;
    if (obs_h() !== want) begin
      n_bad++;
      $display("FAIL reset_in_memwrite: got %h want %h", obs_h(), want);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (state_dbg_h !== S_FETCH || ir_write_h !== 1'b1) begin
      n_bad++;
      $display("FAIL after_reset_fetch: got st=%0d ir=%b want st=0 ir=1", state_dbg_h, ir_write_h);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] o;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: o = 7'b0000011;
        1: o = 7'b0100011;
        2: o = 7'b0110011;
        3: o = 7'b0010011;
        4: o = 7'b1100011;
        default: o = 7'b1101111;
      endcase
      run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_branch();
    test_jal();
    test_itype();
    test_illegal();
    test_reset();
    test_reset_in_memwrite();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
